// File: rtl/dsi_if.sv
// dsi_if: sample/symbol bundle between the rail front end and the rate-4 decimator.
//   en         sample-accept qualifier
//   sync       phase realign (meaningful only with en)
//   hf_in      signed 2-bit high-rate sample
//   lf_out     signed 2-bit decimated symbol (held between strobes)
//   lf_valid   one-cycle strobe, lf_out carries a new symbol
//   frame_done one-cycle strobe on the last symbol of a frame
// master drives samples and observes symbols; slave is the decimator.
interface dsi_if;
  logic              en;
  logic              sync;
  logic signed [1:0] hf_in;
  logic signed [1:0] lf_out;
  logic              lf_valid;
  logic              frame_done;

  modport master (
    output en, sync, hf_in,
    input  lf_out, lf_valid, frame_done
  );

  modport slave (
    input  en, sync, hf_in,
    output lf_out, lf_valid, frame_done
  );
endinterface

// File: rtl/dsi.sv
// dsi: rate-4 downsampler for one QAM receive rail (inverse of the 4x upsampler).
// Accepts one signed 2-bit sample per enabled clk and emits one signed 2-bit symbol
// per four accepted samples, either the sample at phase PICK (MODE=0) or the floored
// mean of the four (MODE=1). sync forces the current sample to phase 0. A symbol
// counter raises frame_done with the last symbol of every N_SYM-symbol frame.
// Ports:
//   clk  4x sample-rate clock
//   rst  synchronous active-low reset
//   bus  dsi_if.slave: en, sync, hf_in in; lf_out, lf_valid, frame_done out
// All outputs are registered.
module dsi #(
  parameter int MODE  = 1,
  parameter int PICK  = 0,
  parameter int N_SYM = 512
) (
  input  logic  clk,
  input  logic  rst,
  dsi_if.slave  bus
);

  localparam logic [1:0] PICK_PH  = 2'(PICK);
  localparam logic [9:0] LAST_SYM = 10'(N_SYM - 1);

  // Floored mean of a four-sample sum. The sum lies in -8..+4, so the
  // arithmetic shift always lands in -2..+1 and never needs saturation.
  function automatic logic signed [1:0] dump_mean(input logic signed [3:0] sum);
    return 2'(sum >>> 2);
  endfunction

  logic        [1:0] ph_q,   ph_d;
  logic signed [3:0] acc_q,  acc_d;
  logic signed [1:0] pick_q, pick_d;
  logic        [9:0] cnt_q,  cnt_d;
  logic signed [1:0] lf_q,   lf_d;
  logic              vld_q,  vld_d;
  logic              fd_q,   fd_d;

  logic signed [3:0] hf_ext;
  logic signed [3:0] sum4;

  assign hf_ext = {{2{bus.hf_in[1]}}, bus.hf_in};
  assign sum4   = acc_q + hf_ext;

  always_comb begin
    ph_d   = ph_q;
    acc_d  = acc_q;
    pick_d = pick_q;
    cnt_d  = cnt_q;
    lf_d   = lf_q;
    vld_d  = 1'b0;
    fd_d   = 1'b0;

    if (bus.en) begin
      if (bus.sync) begin
        // Realign: this sample opens a new symbol; any partial symbol,
        // including one that would complete on this edge, is dropped.
        acc_d = hf_ext;
        ph_d  = 2'd1;
        cnt_d = '0;
        if (PICK_PH == 2'd0) pick_d = bus.hf_in;
      end else begin
        acc_d = (ph_q == 2'd0) ? hf_ext : sum4;
        ph_d  = ph_q + 2'd1;
        if (ph_q == PICK_PH) pick_d = bus.hf_in;

        if (ph_q == 2'd3) begin
          // pick_q is not yet loaded when PICK is the completing phase,
          // so take the live sample in that case.
          if (MODE != 0)             lf_d = dump_mean(sum4);
          else if (PICK_PH == 2'd3)  lf_d = bus.hf_in;
          else                       lf_d = pick_q;
          vld_d = 1'b1;
          if (cnt_q == LAST_SYM) begin
            fd_d  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ph_q   <= '0;
      acc_q  <= '0;
      pick_q <= '0;
      cnt_q  <= '0;
      lf_q   <= '0;
      vld_q  <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      acc_q  <= acc_d;
      pick_q <= pick_d;
      cnt_q  <= cnt_d;
      lf_q   <= lf_d;
      vld_q  <= vld_d;
      fd_q   <= fd_d;
    end
  end

  assign bus.lf_out     = lf_q;
  assign bus.lf_valid   = vld_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_dsi.sv
// tb_dsi: three decimator instances (integrate N_SYM=512, pick phase 2 N_SYM=3,
// pick phase 3 N_SYM=2) share one stimulus stream and are compared against a
// queue-based symbol model.
module tb_dsi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  dsi_if ifa ();
  dsi_if ifb ();
  dsi_if ifc ();

  dsi #(.MODE(1), .PICK(0), .N_SYM(512)) u_int  (.clk(clk), .rst(rst), .bus(ifa));
  dsi #(.MODE(0), .PICK(2), .N_SYM(3))   u_pick2(.clk(clk), .rst(rst), .bus(ifb));
  dsi #(.MODE(0), .PICK(3), .N_SYM(2))   u_pick3(.clk(clk), .rst(rst), .bus(ifc));

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: samples of the symbol in progress, plus per-instance
  // symbol count and expected registered outputs.
  int md[3] = '{1, 0, 0};
  int pk[3] = '{0, 2, 3};
  int ns[3] = '{512, 3, 2};
  int cnt[3];
  int eo[3];
  int ev[3];
  int ef[3];
  int q[$];

  function automatic int floor_div4(input int s);
    if (s >= 0) return s / 4;
    return -((-s + 3) / 4);
  endfunction

  function automatic int sx(input logic [1:0] v);
    logic signed [1:0] t;
    t = v;
    return int'(t);
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit s, input int x);
    int sum;
    if (!r) begin
      q.delete();
      for (int k = 0; k < 3; k++) begin
        cnt[k] = 0; eo[k] = 0; ev[k] = 0; ef[k] = 0;
      end
      return;
    end
    for (int k = 0; k < 3; k++) begin
      ev[k] = 0; ef[k] = 0;
    end
    if (!e) return;
    if (s) begin
      q.delete();
      q.push_back(x);
      for (int k = 0; k < 3; k++) cnt[k] = 0;
      return;
    end
    q.push_back(x);
    if (q.size() == 4) begin
      sum = q[0] + q[1] + q[2] + q[3];
      for (int k = 0; k < 3; k++) begin
        eo[k] = (md[k] != 0) ? floor_div4(sum) : q[pk[k]];
        ev[k] = 1;
        if (cnt[k] == ns[k] - 1) begin
          ef[k] = 1; cnt[k] = 0;
        end else begin
          cnt[k]++;
        end
      end
      q.delete();
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit s, input int x);
    logic [1:0] h;
    h = 2'(x);
    rst = r;
    ifa.en = e; ifa.sync = s; ifa.hf_in = h;
    ifb.en = e; ifb.sync = s; ifb.hf_in = h;
    ifc.en = e; ifc.sync = s; ifc.hf_in = h;
  endtask

  // Apply inputs, clock once, update the model, then settle past the edge.
  task automatic step(input bit r, input bit e, input bit s, input int x);
    drive(r, e, s, x);
    @(posedge clk);
    model_edge(r, e, s, x);
    #1;
  endtask

  task automatic get_act(input int k, output int v, output int o, output int f);
    case (k)
      0:       begin v = int'(ifa.lf_valid); o = sx(ifa.lf_out); f = int'(ifa.frame_done); end
      1:       begin v = int'(ifb.lf_valid); o = sx(ifb.lf_out); f = int'(ifb.frame_done); end
      default: begin v = int'(ifc.lf_valid); o = sx(ifc.lf_out); f = int'(ifc.frame_done); end
    endcase
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 3)) - 2;
  endfunction

  task automatic test_reset();
    int v, o, f;
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    for (int c = 0; c < 3; c++) begin
      step(0, 1, $urandom_range(0, 1), rnd_sample());
      for (int k = 0; k < 3; k++) begin
        get_act(k, v, o, f);
        n_chk++;
        if (v !== 0 || o !== 0 || f !== 0)
          $display("FAIL reset c=%0d k=%0d valid/out/fd got %0d/%0d/%0d want 0/0/0", c, k, v, o, f);
        else n_pass++;
      end
    end
  endtask

  task automatic test_repeat();
    int v, o, f;
    int pat[12] = '{1, 1, 1, 1, -2, -2, -2, -2, 0, 0, 0, 0};
    int exp_sym[3] = '{1, -2, 0};
    int wv, wo;
    step(0, 0, 0, 0);
    wo = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1, 1, 0, pat[i-1]);
      get_act(0, v, o, f);
      wv = (i % 4 == 0) ? 1 : 0;
      if (wv == 1) wo = exp_sym[i/4 - 1];
      n_chk++;
      if (v !== wv || o !== wo || f !== 0)
        $display("FAIL repeat cycle=%0d valid/out/fd got %0d/%0d/%0d want %0d/%0d/0", i + 1, v, o, f, wv, wo);
      else n_pass++;
    end
  endtask

  task automatic test_integrate_pick();
    int v, o, f;
    int s1[4] = '{1, 1, 0, -1};
    int s2[4] = '{-1, 0, 0, 0};
    int s3[4] = '{0, 0, -2, 1};
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, s1[i]);
    get_act(0, v, o, f);
    n_chk++;
    if (v !== 1 || o !== 0) $display("FAIL integ_floor_pos valid/out got %0d/%0d want 1/0", v, o);
    else n_pass++;
    for (int i = 0; i < 4; i++) step(1, 1, 0, s2[i]);
    get_act(0, v, o, f);
    n_chk++;
    if (v !== 1 || o !== -1) $display("FAIL integ_floor_neg valid/out got %0d/%0d want 1/-1", v, o);
    else n_pass++;
    for (int i = 0; i < 4; i++) step(1, 1, 0, s3[i]);
    get_act(1, v, o, f);
    n_chk++;
    if (v !== 1 || o !== -2) $display("FAIL pick2 valid/out got %0d/%0d want 1/-2", v, o);
    else n_pass++;
    get_act(2, v, o, f);
    n_chk++;
    if (v !== 1 || o !== 1) $display("FAIL pick3 valid/out got %0d/%0d want 1/1", v, o);
    else n_pass++;
  endtask

  task automatic test_stall();
    int v, o, f;
    int strobes;
    int s[4] = '{1, -2, 1, 1};
    step(0, 0, 0, 0);
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        for (int c = 0; c < 5; c++) begin
          step(1, 0, $urandom_range(0, 1), rnd_sample());
          get_act(0, v, o, f);
          n_chk++;
          if (v !== 0 || f !== 0) $display("FAIL stall_quiet c=%0d valid/fd got %0d/%0d want 0/0", c, v, f);
          else n_pass++;
        end
      end
      step(1, 1, 0, s[i]);
      get_act(0, v, o, f);
      strobes += v;
    end
    n_chk++;
    if (strobes !== 1 || o !== 0) $display("FAIL stall_symbol strobes/out got %0d/%0d want 1/0", strobes, o);
    else n_pass++;
    get_act(1, v, o, f);
    n_chk++;
    if (v !== 1 || o !== 1) $display("FAIL stall_pick2 valid/out got %0d/%0d want 1/1", v, o);
    else n_pass++;
  endtask

  task automatic test_sync();
    int v, o, f;
    int strobes;
    step(0, 0, 0, 0);
    // One full symbol: pick3 instance (N_SYM=2) now sits at count 1.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1);
    step(1, 1, 0, -2);
    step(1, 1, 0, -2);
    step(1, 1, 1, 1);       // realign: this sample is phase 0
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      get_act(0, v, o, f);
      strobes += v;
      step(1, 1, 0, 0);
    end
    n_chk++;
    if (strobes !== 0) $display("FAIL sync_early strobes got %0d want 0", strobes);
    else n_pass++;
    get_act(0, v, o, f);
    n_chk++;
    if (v !== 1 || o !== 0) $display("FAIL sync_strobe valid/out got %0d/%0d want 1/0", v, o);
    else n_pass++;
    get_act(2, v, o, f);
    n_chk++;
    if (v !== 1 || f !== 0 || o !== 0) $display("FAIL sync_cnt_restart valid/fd/out got %0d/%0d/%0d want 1/0/0", v, f, o);
    else n_pass++;
    for (int i = 0; i < 4; i++) step(1, 1, 0, -1);
    get_act(2, v, o, f);
    n_chk++;
    if (v !== 1 || f !== 1 || o !== -1) $display("FAIL sync_frame2 valid/fd/out got %0d/%0d/%0d want 1/1/-1", v, f, o);
    else n_pass++;
    // sync landing on what would be the completing phase
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1);
    step(1, 1, 1, -2);
    get_act(0, v, o, f);
    n_chk++;
    if (v !== 0 || f !== 0) $display("FAIL sync_ph3 valid/fd got %0d/%0d want 0/0", v, f);
    else n_pass++;
    for (int i = 0; i < 3; i++) step(1, 1, 0, -2);
    get_act(0, v, o, f);
    n_chk++;
    if (v !== 1 || o !== -2) $display("FAIL sync_ph3_next valid/out got %0d/%0d want 1/-2", v, o);
    else n_pass++;
  endtask

  task automatic test_random();
    int v, o, f;
    bit r, e, s;
    step(0, 0, 0, 0);
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 99) != 0);
      e = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 29) == 0);
      step(r, e, s, rnd_sample());
      for (int k = 0; k < 3; k++) begin
        get_act(k, v, o, f);
        n_chk++;
        if (v !== ev[k] || o !== eo[k] || f !== ef[k])
          $display("FAIL random c=%0d k=%0d valid/out/fd got %0d/%0d/%0d want %0d/%0d/%0d",
                   c, k, v, o, f, ev[k], eo[k], ef[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_frame();
    int v, o, f;
    int sym, strobes, errs, wv, wf;
    step(0, 0, 0, 0);
    strobes = 0;
    errs = 0;
    for (int s = 0; s < 513; s++) begin
      sym = rnd_sample();
      for (int p = 0; p < 4; p++) begin
        step(1, 1, 0, sym);
        get_act(0, v, o, f);
        strobes += v;
        wv = (p == 3) ? 1 : 0;
        wf = (p == 3 && s == 511) ? 1 : 0;
        if (v !== wv || f !== wf || (p == 3 && o !== sym)) begin
          errs++;
          if (errs <= 5)
            $display("FAIL frame sym=%0d ph=%0d valid/out/fd got %0d/%0d/%0d want %0d/%0d/%0d",
                     s, p, v, o, f, wv, sym, wf);
        end
      end
    end
    n_chk++;
    if (errs !== 0) $display("FAIL frame_stream errors got %0d want 0", errs);
    else n_pass++;
    n_chk++;
    if (strobes !== 513) $display("FAIL frame_strobes got %0d want 513", strobes);
    else n_pass++;
  endtask

  initial begin
    drive(0, 0, 0, 0);
    test_reset();
    test_repeat();
    test_integrate_pick();
    test_stall();
    test_sync();
    test_random();
    test_frame();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
